// File: rtl/tmds_channel_decoder.sv
// TMDS receive channel: bit-slip word alignment on control tokens, then 10b->8b/2b decode.
// Optional macro TMDS_DECODER_ERR_COUNT_EN adds a saturating alignment-error counter port.
module tmds_channel_decoder #(
  parameter int SEARCH_TIMEOUT = 16,
  parameter int LOCK_TOKENS    = 8,
  parameter int LOSS_TIMEOUT   = 4096
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [9:0] raw_in,
  output logic [7:0] data_out,
  output logic [1:0] ctrl_out,
  output logic       de_out,
  output logic       locked,
  output logic [3:0] slip_offset,
  output logic       lock_lost
`ifdef TMDS_DECODER_ERR_COUNT_EN
  ,
  output logic [15:0] err_count
`endif
);

  localparam int TMO_W  = (SEARCH_TIMEOUT > 1) ? $clog2(SEARCH_TIMEOUT) : 1;
  localparam int VCNT_W = $clog2(LOCK_TOKENS + 1);
  localparam int LCNT_W = $clog2(LOSS_TIMEOUT + 1);

  localparam logic [TMO_W-1:0]  TMO_LAST  = TMO_W'(SEARCH_TIMEOUT - 1);
  localparam logic [VCNT_W-1:0] VCNT_DONE = VCNT_W'(LOCK_TOKENS);
  localparam logic [LCNT_W-1:0] LCNT_LAST = LCNT_W'(LOSS_TIMEOUT - 1);

  typedef enum logic [1:0] {
    ST_SEARCH = 2'd0,
    ST_VERIFY = 2'd1,
    ST_LOCKED = 2'd2
  } state_t;

  // Bit 0 of the result is the token-seen flag, bits 2:1 the control value {C1,C0}.
  function automatic logic [2:0] token_lookup(input logic [9:0] w);
    logic [2:0] r;
    case (w)
      10'b1101010100: r = 3'b001;
      10'b0010101011: r = 3'b011;
      10'b0101010100: r = 3'b101;
      10'b1010101011: r = 3'b111;
      default:        r = 3'b000;
    endcase
    return r;
  endfunction

  function automatic logic [7:0] tmds_decode(input logic [9:0] w);
    logic [7:0] d;
    logic [7:0] q;
    d    = w[9] ? ~w[7:0] : w[7:0];
    q    = 8'd0;
    q[0] = d[0];
    for (int i = 1; i < 8; i++) begin
      q[i] = w[8] ? (d[i] ^ d[i-1]) : ~(d[i] ^ d[i-1]);
    end
    return q;
  endfunction

  state_t            state_r, state_s;
  logic [9:0]        cur_r, prev_r;
  logic [3:0]        offset_r, offset_s, offset_inc_s;
  logic [TMO_W-1:0]  tmo_r, tmo_s;
  logic [VCNT_W-1:0] vcnt_r, vcnt_s;
  logic [LCNT_W-1:0] lcnt_r, lcnt_s;
  logic              lost_s, abort_s;
  logic [19:0]       pair_s;
  logic [9:0]        win_s;
  logic [2:0]        tok_s;

  assign pair_s       = {cur_r, prev_r};
  assign win_s        = 10'(pair_s >> offset_r);
  assign tok_s        = token_lookup(win_s);
  assign offset_inc_s = (offset_r == 4'd9) ? 4'd0 : offset_r + 4'd1;
  assign slip_offset  = offset_r;

  // Alignment FSM next-state: search/slip, token verification, lock supervision.
  always_comb begin
    state_s  = state_r;
    offset_s = offset_r;
    tmo_s    = tmo_r;
    vcnt_s   = vcnt_r;
    lcnt_s   = lcnt_r;
    lost_s   = 1'b0;
    abort_s  = 1'b0;
    case (state_r)
      ST_SEARCH: begin
        if (tok_s[0]) begin
          state_s = ST_VERIFY;
          vcnt_s  = VCNT_W'(1);
          tmo_s   = '0;
        end else if (tmo_r == TMO_LAST) begin
          offset_s = offset_inc_s;
          tmo_s    = '0;
        end else begin
          tmo_s = tmo_r + TMO_W'(1);
        end
      end
      ST_VERIFY: begin
        // Lock is declared once the counter has been registered at its target.
        if (vcnt_r == VCNT_DONE) begin
          state_s = ST_LOCKED;
          vcnt_s  = '0;
          lcnt_s  = '0;
        end else if (tok_s[0]) begin
          vcnt_s = vcnt_r + VCNT_W'(1);
        end else begin
          state_s  = ST_SEARCH;
          offset_s = offset_inc_s;
          tmo_s    = '0;
          vcnt_s   = '0;
          abort_s  = 1'b1;
        end
      end
      ST_LOCKED: begin
        if (tok_s[0]) begin
          lcnt_s = '0;
        end else if (lcnt_r == LCNT_LAST) begin
          state_s = ST_SEARCH;
          lcnt_s  = '0;
          tmo_s   = '0;
          lost_s  = 1'b1;
        end else begin
          lcnt_s = lcnt_r + LCNT_W'(1);
        end
      end
      default: begin
        state_s = ST_SEARCH;
      end
    endcase
  end

  // Word pipeline, FSM state and registered decode outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      cur_r     <= 10'd0;
      prev_r    <= 10'd0;
      state_r   <= ST_SEARCH;
      offset_r  <= 4'd0;
      tmo_r     <= '0;
      vcnt_r    <= '0;
      lcnt_r    <= '0;
      data_out  <= 8'd0;
      ctrl_out  <= 2'd0;
      de_out    <= 1'b0;
      locked    <= 1'b0;
      lock_lost <= 1'b0;
    end else begin
      cur_r     <= raw_in;
      prev_r    <= cur_r;
      state_r   <= state_s;
      offset_r  <= offset_s;
      tmo_r     <= tmo_s;
      vcnt_r    <= vcnt_s;
      lcnt_r    <= lcnt_s;
      locked    <= (state_s == ST_LOCKED);
      lock_lost <= lost_s;
      if (state_r != ST_LOCKED) begin
        data_out <= 8'd0;
        ctrl_out <= 2'd0;
        de_out   <= 1'b0;
      end else if (tok_s[0]) begin
        data_out <= 8'd0;
        ctrl_out <= tok_s[2:1];
        de_out   <= 1'b0;
      end else begin
        data_out <= tmds_decode(win_s);
        de_out   <= 1'b1;
      end
    end
  end

`ifdef TMDS_DECODER_ERR_COUNT_EN
  // Counts verification aborts and lock losses, saturating at all-ones.
  always_ff @(posedge clk) begin
    if (rst) begin
      err_count <= 16'd0;
    end else if ((abort_s || lost_s) && (err_count != 16'hFFFF)) begin
      err_count <= err_count + 16'd1;
    end else begin
      err_count <= err_count;
    end
  end
`endif

endmodule

// File: tb/tb_tmds_channel_decoder.sv
// Directed self-checking bench for tmds_channel_decoder (default parameters).
module tb_tmds_channel_decoder;

  localparam logic [9:0] TOK00 = 10'b1101010100;
  localparam logic [9:0] TOK11 = 10'b1010101011;
  localparam logic [9:0] DLY00 = 10'b1010100110; // token 00 stream shifted by 3 serial bits
  localparam logic [9:0] W00   = 10'b0100000000; // 0x00, xor mode
  localparam logic [9:0] W55   = 10'b0010011001; // 0x55, xnor mode
  localparam logic [9:0] WFF   = 10'b1110101010; // 0xFF, xor mode, inverted
  localparam logic [9:0] W10   = 10'b0111110000; // 0x10, xor mode

  logic       clk;
  logic       rst;
  logic [9:0] raw_in;
  logic [7:0] data_out;
  logic [1:0] ctrl_out;
  logic       de_out;
  logic       locked;
  logic [3:0] slip_offset;
  logic       lock_lost;
`ifdef TMDS_DECODER_ERR_COUNT_EN
  logic [15:0] err_count;
`endif

  int checks;
  int errors;

  tmds_channel_decoder dut (
    .clk        (clk),
    .rst        (rst),
    .raw_in     (raw_in),
    .data_out   (data_out),
    .ctrl_out   (ctrl_out),
    .de_out     (de_out),
    .locked     (locked),
    .slip_offset(slip_offset),
    .lock_lost  (lock_lost)
`ifdef TMDS_DECODER_ERR_COUNT_EN
    ,
    .err_count  (err_count)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One reset edge; the next tick is the first released edge.
  task automatic pulse_reset();
    rst = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    raw_in = 10'h3A5;
    rst    = 1'b1;
    tick();
    tick();
    checks++;
    if ({data_out, ctrl_out, de_out, locked, slip_offset, lock_lost} !== 17'd0) begin
      errors++;
      $display("FAIL reset_outputs got data=%h ctrl=%b de=%b locked=%b off=%0d lost=%b want all 0",
               data_out, ctrl_out, de_out, locked, slip_offset, lock_lost);
    end
  endtask

  task automatic test_align_offset0();
    logic off_bad;
    off_bad = 1'b0;
    raw_in  = TOK00;
    pulse_reset();
    for (int k = 1; k <= 12; k++) begin
      tick();
      if (slip_offset !== 4'd0) off_bad = 1'b1;
      if (k == 10) begin
        checks++;
        if (locked !== 1'b0) begin
          errors++;
          $display("FAIL align0_early got locked=%b want 0 at cycle 10", locked);
        end
      end
      if (k == 11) begin
        checks++;
        if (locked !== 1'b1) begin
          errors++;
          $display("FAIL align0_lock got locked=%b want 1 at cycle 11", locked);
        end
      end
    end
    checks++;
    if (off_bad !== 1'b0) begin
      errors++;
      $display("FAIL align0_offset got slip_offset moved (now %0d) want constant 0", slip_offset);
    end
    checks++;
    if ({ctrl_out, de_out, data_out} !== 11'd0) begin
      errors++;
      $display("FAIL align0_ctrl got ctrl=%b de=%b data=%h want 00 0 00", ctrl_out, de_out, data_out);
    end
  endtask

  task automatic test_decode();
    logic [9:0] seq  [8];
    logic [7:0] exp_d[6];
    logic [1:0] exp_c[6];
    logic       exp_e[6];
    seq = '{W00, W55, WFF, W10, TOK11, TOK11, TOK11, TOK11};
    exp_d = '{8'h00, 8'h55, 8'hFF, 8'h10, 8'h00, 8'h00};
    exp_c = '{2'b00, 2'b00, 2'b00, 2'b00, 2'b11, 2'b11};
    exp_e = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
    for (int i = 0; i < 8; i++) begin
      raw_in = seq[i];
      tick();
      if (i >= 2) begin
        checks++;
        if ({data_out, ctrl_out, de_out} !== {exp_d[i-2], exp_c[i-2], exp_e[i-2]}) begin
          errors++;
          $display("FAIL decode_%0d got data=%h ctrl=%b de=%b want data=%h ctrl=%b de=%b",
                   i - 2, data_out, ctrl_out, de_out, exp_d[i-2], exp_c[i-2], exp_e[i-2]);
        end
      end
    end
  endtask

  task automatic test_loss();
    int pulses;
    int pulse_at;
    logic [3:0] off_at;
    logic lk_at;
    pulses = 0;
    raw_in = W00;
    for (int i = 1; i <= 4095; i++) begin
      tick();
      if (lock_lost === 1'b1) pulses++;
    end
    raw_in = TOK00;
    for (int i = 0; i < 4; i++) begin
      tick();
      if (lock_lost === 1'b1) pulses++;
    end
    checks++;
    if (locked !== 1'b1 || pulses != 0) begin
      errors++;
      $display("FAIL loss_4095 got locked=%b pulses=%0d want locked=1 pulses=0", locked, pulses);
    end
    pulse_at = -1;
    off_at   = 4'hF;
    lk_at    = 1'b1;
    raw_in   = W00;
    for (int i = 1; i <= 4110; i++) begin
      tick();
      if (i == 100) begin
        checks++;
        if (de_out !== 1'b1 || data_out !== 8'h00) begin
          errors++;
          $display("FAIL loss_data got de=%b data=%h want de=1 data=00", de_out, data_out);
        end
      end
      if (lock_lost === 1'b1) begin
        pulses++;
        if (pulse_at < 0) begin
          pulse_at = i;
          off_at   = slip_offset;
          lk_at    = locked;
        end
      end
    end
    checks++;
    if (pulses != 1 || pulse_at != 4098) begin
      errors++;
      $display("FAIL loss_pulse got pulses=%0d at cycle %0d want 1 at cycle 4098", pulses, pulse_at);
    end
    checks++;
    if (lk_at !== 1'b0 || off_at !== 4'd0) begin
      errors++;
      $display("FAIL loss_state got locked=%b off=%0d want locked=0 off=0", lk_at, off_at);
    end
  endtask

  task automatic test_verify_abort();
    raw_in = TOK00;
    pulse_reset();
    for (int k = 1; k <= 8; k++) begin
      if (k == 6) raw_in = W55;
      else raw_in = TOK00;
      tick();
      if (k == 7) begin
        checks++;
        if (slip_offset !== 4'd0 || locked !== 1'b0) begin
          errors++;
          $display("FAIL abort_pre got off=%0d locked=%b want off=0 locked=0", slip_offset, locked);
        end
      end
    end
    checks++;
    if (slip_offset !== 4'd1 || locked !== 1'b0 || lock_lost !== 1'b0) begin
      errors++;
      $display("FAIL abort_slip got off=%0d locked=%b lost=%b want off=1 locked=0 lost=0",
               slip_offset, locked, lock_lost);
    end
`ifdef TMDS_DECODER_ERR_COUNT_EN
    checks++;
    if (err_count !== 16'd1) begin
      errors++;
      $display("FAIL abort_errcnt got %0d want 1", err_count);
    end
`endif
  endtask

  task automatic test_align_offset3();
    logic [3:0] exp_off;
    logic       off_bad;
    off_bad = 1'b0;
    raw_in  = DLY00;
    pulse_reset();
    for (int k = 1; k <= 80; k++) begin
      tick();
      exp_off = (k >= 48) ? 4'd3 : 4'((k / 16));
      if (slip_offset !== exp_off) off_bad = 1'b1;
      if (k == 56) begin
        checks++;
        if (locked !== 1'b0) begin
          errors++;
          $display("FAIL align3_early got locked=%b want 0 at cycle 56", locked);
        end
      end
      if (k == 57) begin
        checks++;
        if (locked !== 1'b1) begin
          errors++;
          $display("FAIL align3_lock got locked=%b want 1 at cycle 57", locked);
        end
      end
    end
    checks++;
    if (off_bad !== 1'b0) begin
      errors++;
      $display("FAIL align3_offset got off=%0d (schedule broken) want 0,1,2,3 at 16-cycle steps",
               slip_offset);
    end
  endtask

  task automatic test_reset_while_locked();
    logic lost_seen;
    lost_seen = 1'b0;
    raw_in    = DLY00;
    rst       = 1'b1;
    tick();
    checks++;
    if ({data_out, ctrl_out, de_out, locked, slip_offset, lock_lost} !== 17'd0) begin
      errors++;
      $display("FAIL rst_locked got data=%h ctrl=%b de=%b locked=%b off=%0d lost=%b want all 0",
               data_out, ctrl_out, de_out, locked, slip_offset, lock_lost);
    end
    rst = 1'b0;
    for (int k = 1; k <= 57; k++) begin
      tick();
      if (lock_lost === 1'b1) lost_seen = 1'b1;
      if (k == 56) begin
        checks++;
        if (locked !== 1'b0) begin
          errors++;
          $display("FAIL relock_early got locked=%b want 0 at cycle 56", locked);
        end
      end
    end
    checks++;
    if (locked !== 1'b1 || slip_offset !== 4'd3 || lost_seen !== 1'b0) begin
      errors++;
      $display("FAIL relock got locked=%b off=%0d lost_seen=%b want 1 3 0",
               locked, slip_offset, lost_seen);
    end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    rst    = 1'b1;
    raw_in = 10'd0;
    test_reset();
    test_align_offset0();
    test_decode();
    test_loss();
    test_verify_abort();
    test_align_offset3();
    test_reset_while_locked();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
